// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: paddle motion, ball flight, collisions, scoring, win detection.
// Latency: one clk; an update caused by frame_tick is visible on the outputs the next cycle.
// Backpressure: none; inputs are sampled every cycle and outputs are always valid.

module pong_game_ctrl #(
    parameter int         H_RES        = 640,
    parameter int         V_RES        = 480,
    parameter int         PADDLE_H     = 64,
    parameter int         PADDLE_W     = 8,
    parameter int         PADDLE1_X    = 16,
    parameter int         PADDLE2_X    = 616,
    parameter int         PADDLE_STEP  = 8,
    parameter int         BALL_SIZE    = 8,
    parameter int         BALL_SPEED   = 4,
    parameter int         WIN_SCORE    = 9,
    parameter int         POINT_FRAMES = 60,
    parameter logic [3:0] KEY_UP       = 4'h1,
    parameter logic [3:0] KEY_DOWN     = 4'h4,
    parameter logic [3:0] KEY_SERVE    = 4'h5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [3:0] keys_1,
    input  logic       keypressed_1,
    input  logic [3:0] keys_2,
    input  logic       keypressed_2,
    output logic [9:0] paddle1_y,
    output logic [9:0] paddle2_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [2:0] game_state,
    output logic [1:0] winner
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam int CNT_W = (POINT_FRAMES > 1) ? $clog2(POINT_FRAMES) : 1;

    localparam logic [9:0]  L_PAD_INIT = 10'((V_RES - PADDLE_H) / 2);
    localparam logic [9:0]  L_BALL_CX  = 10'((H_RES - BALL_SIZE) / 2);
    localparam logic [9:0]  L_BALL_CY  = 10'((V_RES - BALL_SIZE) / 2);
    localparam logic [10:0] L_PAD_STEP = 11'(PADDLE_STEP);
    localparam logic [10:0] L_PAD_MAX  = 11'(V_RES - PADDLE_H);

    // Ball arithmetic is signed 11-bit so that a step past the top/left edge goes negative.
    localparam logic signed [10:0] L_SPEED      = 11'(BALL_SPEED);
    localparam logic signed [10:0] L_BSIZE      = 11'(BALL_SIZE);
    localparam logic signed [10:0] L_PAD_H      = 11'(PADDLE_H);
    localparam logic signed [10:0] L_BALL_MAX_X = 11'(H_RES - BALL_SIZE);
    localparam logic signed [10:0] L_BALL_MAX_Y = 11'(V_RES - BALL_SIZE);
    localparam logic signed [10:0] L_P1_X       = 11'(PADDLE1_X);
    localparam logic signed [10:0] L_P1_FACE    = 11'(PADDLE1_X + PADDLE_W);
    localparam logic signed [10:0] L_P2_X       = 11'(PADDLE2_X);
    localparam logic signed [10:0] L_P2_BACK    = 11'(PADDLE2_X + PADDLE_W);
    localparam logic signed [10:0] L_P2_FACE    = 11'(PADDLE2_X - BALL_SIZE);

    localparam logic [3:0]       L_WIN      = 4'(WIN_SCORE);
    localparam logic [CNT_W-1:0] L_CNT_LAST = CNT_W'(POINT_FRAMES - 1);

    // Registered game state
    state_t           r_state;
    logic [9:0]       r_paddle1_y;
    logic [9:0]       r_paddle2_y;
    logic [9:0]       r_ball_x;
    logic [9:0]       r_ball_y;
    logic             r_dx;         // 1 = moving right
    logic             r_dy;         // 1 = moving down
    logic [3:0]       r_score1;
    logic [3:0]       r_score2;
    logic [1:0]       r_winner;
    logic [CNT_W-1:0] r_pt_cnt;
    logic             r_start_q;

    // Next-state values
    state_t           w_state_nxt;
    logic [9:0]       w_p1_nxt;
    logic [9:0]       w_p2_nxt;
    logic [9:0]       w_bx_nxt;
    logic [9:0]       w_by_nxt;
    logic             w_dx_nxt;
    logic             w_dy_nxt;
    logic [3:0]       w_s1_nxt;
    logic [3:0]       w_s2_nxt;
    logic [1:0]       w_win_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Ball flight intermediates
    logic signed [10:0] w_bx;
    logic signed [10:0] w_by;
    logic signed [10:0] w_p1y;
    logic signed [10:0] w_p2y;
    logic signed [10:0] w_nx0;
    logic signed [10:0] w_ny0;
    logic signed [10:0] w_nx1;
    logic signed [10:0] w_ny1;
    logic               w_dx1;
    logic               w_dy1;
    logic               w_hit1;
    logic               w_hit2;
    logic               w_miss_l;
    logic               w_miss_r;

    logic w_start_rise;
    logic w_serve;
    logic w_paddles_live;

    assign w_start_rise   = start & ~r_start_q;
    assign w_serve        = (keypressed_1 && keys_1 == KEY_SERVE) ||
                            (keypressed_2 && keys_2 == KEY_SERVE);
    assign w_paddles_live = frame_tick &&
                            (r_state == S_SERVE || r_state == S_PLAY || r_state == S_POINT);

    // One paddle step with saturation at the top and bottom of the screen
    function automatic logic [9:0] paddle_next(input logic [9:0] y,
                                               input logic       held,
                                               input logic [3:0] code);
        logic [10:0] t;
        t = {1'b0, y};
        if (held && code == KEY_UP) begin
            t = (t < L_PAD_STEP) ? 11'd0 : (t - L_PAD_STEP);
        end else if (held && code == KEY_DOWN) begin
            t = ((t + L_PAD_STEP) > L_PAD_MAX) ? L_PAD_MAX : (t + L_PAD_STEP);
        end
        return t[9:0];
    endfunction

    // Candidate ball move for this frame: step, wall bounce, paddle bounce, then miss detection
    always_comb begin
        w_bx  = $signed({1'b0, r_ball_x});
        w_by  = $signed({1'b0, r_ball_y});
        w_p1y = $signed({1'b0, r_paddle1_y});
        w_p2y = $signed({1'b0, r_paddle2_y});

        w_nx0 = r_dx ? (w_bx + L_SPEED) : (w_bx - L_SPEED);
        w_ny0 = r_dy ? (w_by + L_SPEED) : (w_by - L_SPEED);

        w_ny1 = w_ny0;
        w_dy1 = r_dy;
        if (w_ny0 < 11'sd0) begin
            w_ny1 = 11'sd0;
            w_dy1 = 1'b1;
        end else if (w_ny0 > L_BALL_MAX_Y) begin
            w_ny1 = L_BALL_MAX_Y;
            w_dy1 = 1'b0;
        end

        // Paddle tests use the wall-corrected row so a corner hit applies both bounces
        w_hit1 = !r_dx && (w_nx0 <= L_P1_FACE) && ((w_nx0 + L_BSIZE) > L_P1_X) &&
                 ((w_ny1 + L_BSIZE) > w_p1y) && (w_ny1 < (w_p1y + L_PAD_H));
        w_hit2 = r_dx && ((w_nx0 + L_BSIZE) >= L_P2_X) && (w_nx0 < L_P2_BACK) &&
                 ((w_ny1 + L_BSIZE) > w_p2y) && (w_ny1 < (w_p2y + L_PAD_H));

        // A paddle return always beats a miss in the same frame
        w_miss_l = !r_dx && !w_hit1 && (w_nx0 <= 11'sd0);
        w_miss_r = r_dx && !w_hit2 && (w_nx0 >= L_BALL_MAX_X);

        w_nx1 = w_nx0;
        w_dx1 = r_dx;
        if (w_hit1) begin
            w_nx1 = L_P1_FACE;
            w_dx1 = 1'b1;
        end else if (w_hit2) begin
            w_nx1 = L_P2_FACE;
            w_dx1 = 1'b0;
        end else if (w_miss_l) begin
            // Keep the exit column on screen even if the speed overshoots the edge
            w_nx1 = (w_nx0 < 11'sd0) ? 11'sd0 : w_nx0;
            w_dx1 = 1'b1;
        end else if (w_miss_r) begin
            w_nx1 = (w_nx0 > L_BALL_MAX_X) ? L_BALL_MAX_X : w_nx0;
            w_dx1 = 1'b0;
        end
    end

    // Next-state and next-value logic for the game FSM
    always_comb begin
        w_state_nxt = r_state;
        w_p1_nxt    = r_paddle1_y;
        w_p2_nxt    = r_paddle2_y;
        w_bx_nxt    = r_ball_x;
        w_by_nxt    = r_ball_y;
        w_dx_nxt    = r_dx;
        w_dy_nxt    = r_dy;
        w_s1_nxt    = r_score1;
        w_s2_nxt    = r_score2;
        w_win_nxt   = r_winner;
        w_cnt_nxt   = r_pt_cnt;

        if (w_paddles_live) begin
            w_p1_nxt = paddle_next(r_paddle1_y, keypressed_1, keys_1);
            w_p2_nxt = paddle_next(r_paddle2_y, keypressed_2, keys_2);
        end

        case (r_state)
            S_IDLE, S_OVER: begin
                // New game: full ball state back to power-on values
                if (w_start_rise) begin
                    w_state_nxt = S_SERVE;
                    w_s1_nxt    = 4'd0;
                    w_s2_nxt    = 4'd0;
                    w_win_nxt   = 2'd0;
                    w_bx_nxt    = L_BALL_CX;
                    w_by_nxt    = L_BALL_CY;
                    w_dx_nxt    = 1'b1;
                    w_dy_nxt    = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end
            S_SERVE: begin
                w_bx_nxt = L_BALL_CX;
                w_by_nxt = L_BALL_CY;
                if (w_serve) begin
                    w_state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                if (frame_tick) begin
                    w_bx_nxt = w_nx1[9:0];
                    w_by_nxt = w_ny1[9:0];
                    w_dx_nxt = w_dx1;
                    w_dy_nxt = w_dy1;
                    if (w_miss_l) begin
                        w_s2_nxt    = r_score2 + 4'd1;
                        w_state_nxt = S_POINT;
                    end else if (w_miss_r) begin
                        w_s1_nxt    = r_score1 + 4'd1;
                        w_state_nxt = S_POINT;
                    end
                end
            end
            S_POINT: begin
                if (frame_tick) begin
                    if (r_pt_cnt == L_CNT_LAST) begin
                        w_cnt_nxt = '0;
                        w_bx_nxt  = L_BALL_CX;
                        w_by_nxt  = L_BALL_CY;
                        // dx already points at the scorer, so it names whose score just moved
                        if (!r_dx && r_score1 == L_WIN) begin
                            w_state_nxt = S_OVER;
                            w_win_nxt   = 2'd1;
                        end else if (r_dx && r_score2 == L_WIN) begin
                            w_state_nxt = S_OVER;
                            w_win_nxt   = 2'd2;
                        end else begin
                            w_state_nxt = S_SERVE;
                        end
                    end else begin
                        w_cnt_nxt = r_pt_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_paddle1_y <= L_PAD_INIT;
            r_paddle2_y <= L_PAD_INIT;
            r_ball_x    <= L_BALL_CX;
            r_ball_y    <= L_BALL_CY;
            r_dx        <= 1'b1;
            r_dy        <= 1'b1;
            r_score1    <= 4'd0;
            r_score2    <= 4'd0;
            r_winner    <= 2'd0;
            r_pt_cnt    <= '0;
            r_start_q   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_paddle1_y <= w_p1_nxt;
            r_paddle2_y <= w_p2_nxt;
            r_ball_x    <= w_bx_nxt;
            r_ball_y    <= w_by_nxt;
            r_dx        <= w_dx_nxt;
            r_dy        <= w_dy_nxt;
            r_score1    <= w_s1_nxt;
            r_score2    <= w_s2_nxt;
            r_winner    <= w_win_nxt;
            r_pt_cnt    <= w_cnt_nxt;
            r_start_q   <= start;
        end
    end

    assign paddle1_y  = r_paddle1_y;
    assign paddle2_y  = r_paddle2_y;
    assign ball_x     = r_ball_x;
    assign ball_y     = r_ball_y;
    assign score1     = r_score1;
    assign score2     = r_score2;
    assign game_state = r_state;
    assign winner     = r_winner;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with a behavioural game model feeding a scoreboard.
// Latency: model predicts the value registered at each clk edge; compared 1 time unit later.
// Backpressure: none; the bench drives keys from the model to play a complete match.

module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic [3:0] keys_1 = 4'h0;
    logic       keypressed_1 = 1'b0;
    logic [3:0] keys_2 = 4'h0;
    logic       keypressed_2 = 1'b0;
    logic [9:0] paddle1_y, paddle2_y, ball_x, ball_y;
    logic [3:0] score1, score2;
    logic [2:0] game_state;
    logic [1:0] winner;

    pong_game_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .start        (start),
        .keys_1       (keys_1),
        .keypressed_1 (keypressed_1),
        .keys_2       (keys_2),
        .keypressed_2 (keypressed_2),
        .paddle1_y    (paddle1_y),
        .paddle2_y    (paddle2_y),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .score1       (score1),
        .score2       (score2),
        .game_state   (game_state),
        .winner       (winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st, p1, p2, bx, by, s1, s2, win;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference game model, plain integer arithmetic
    int m_st, m_p1, m_p2, m_bx, m_by, m_dx, m_dy, m_s1, m_s2, m_win, m_cnt;
    bit m_sq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int pmove(input int y, input logic held, input logic [3:0] code);
        int r;
        r = y;
        if (held && code == 4'h1) r = (y - 8 < 0) ? 0 : y - 8;
        else if (held && code == 4'h4) r = (y + 8 > 416) ? 416 : y + 8;
        return r;
    endfunction

    task automatic model_reset();
        m_st = 0; m_p1 = 208; m_p2 = 208; m_bx = 316; m_by = 236;
        m_dx = 1; m_dy = 1; m_s1 = 0; m_s2 = 0; m_win = 0; m_cnt = 0; m_sq = 0;
    endtask

    task automatic model_step();
        int  nx, ny, st0, p1_old, p2_old;
        bit  rise;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rise   = start && !m_sq;
        m_sq   = start;
        st0    = m_st;
        p1_old = m_p1;
        p2_old = m_p2;
        case (m_st)
            0, 4: if (rise) begin
                m_st = 1; m_s1 = 0; m_s2 = 0; m_win = 0;
                m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1; m_cnt = 0;
            end
            1: if ((keypressed_1 && keys_1 == 4'h5) || (keypressed_2 && keys_2 == 4'h5)) m_st = 2;
            2: if (frame_tick) begin
                nx = m_bx + 4 * m_dx;
                ny = m_by + 4 * m_dy;
                if (ny < 0) begin ny = 0; m_dy = 1; end
                else if (ny > 472) begin ny = 472; m_dy = -1; end
                if (m_dx < 0 && nx <= 24 && nx + 8 > 16 && ny + 8 > p1_old && ny < p1_old + 64) begin
                    nx = 24; m_dx = 1;
                end else if (m_dx > 0 && nx + 8 >= 616 && nx < 624 && ny + 8 > p2_old && ny < p2_old + 64) begin
                    nx = 608; m_dx = -1;
                end else if (m_dx < 0 && nx <= 0) begin
                    m_s2++; m_dx = 1; m_st = 3;
                end else if (m_dx > 0 && nx >= 632) begin
                    m_s1++; m_dx = -1; m_st = 3;
                end
                m_bx = nx;
                m_by = ny;
            end
            3: if (frame_tick) begin
                m_cnt++;
                if (m_cnt == 60) begin
                    m_cnt = 0; m_bx = 316; m_by = 236;
                    if (m_s1 == 9) begin m_st = 4; m_win = 1; end
                    else if (m_s2 == 9) begin m_st = 4; m_win = 2; end
                    else m_st = 1;
                end
            end
            default: ;
        endcase
        if (frame_tick && st0 >= 1 && st0 <= 3) begin
            m_p1 = pmove(p1_old, keypressed_1, keys_1);
            m_p2 = pmove(p2_old, keypressed_2, keys_2);
        end
    endtask

    // One clock: predict, push, advance, pop and compare every output
    task automatic cyc();
        exp_t e;
        model_step();
        e.st = m_st; e.p1 = m_p1; e.p2 = m_p2; e.bx = m_bx; e.by = m_by;
        e.s1 = m_s1; e.s2 = m_s2; e.win = m_win;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("state", game_state, e.st);
        chk("paddle1_y", paddle1_y, e.p1);
        chk("paddle2_y", paddle2_y, e.p2);
        chk("ball_x", ball_x, e.bx);
        chk("ball_y", ball_y, e.by);
        chk("score1", score1, e.s1);
        chk("score2", score2, e.s2);
        chk("winner", winner, e.win);
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
    endtask

    // Row at which the ball will reach paddle 2's face, following wall bounces
    function automatic int pred_y();
        int x, y, d;
        x = m_bx; y = m_by; d = m_dy;
        while (x < 608) begin
            x += 4;
            y += 4 * d;
            if (y < 0) begin y = 0; d = 1; end
            else if (y > 472) begin y = 472; d = -1; end
        end
        return y;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, game_state, 0);
        chk({tag, "_p1"}, paddle1_y, 208);
        chk({tag, "_p2"}, paddle2_y, 208);
        chk({tag, "_bx"}, ball_x, 316);
        chk({tag, "_by"}, ball_y, 236);
        chk({tag, "_s1"}, score1, 0);
        chk({tag, "_s2"}, score2, 0);
        chk({tag, "_win"}, winner, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2;
        model_reset();

        // Reset with frame_tick pulsing: ticks must be ignored
        rst_n = 1'b0;
        repeat (3) begin frame_tick = 1'b1; cyc(); end
        frame_tick = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk_reset_vals("reset");

        // Idle frames change nothing
        frame();
        frame();
        chk_reset_vals("idle");

        // Start edge -> SERVE, player-1 serve -> PLAY
        start = 1'b1; cyc(); start = 1'b0;
        chk("start_to_serve", game_state, 1);
        cyc();
        keypressed_1 = 1'b1; keys_1 = 4'h5; cyc();
        chk("serve_to_play", game_state, 2);
        keypressed_1 = 1'b0; keys_1 = 4'h0; cyc();
        frame();
        chk("first_move_x", ball_x, 320);
        chk("first_move_y", ball_y, 240);

        // Paddle 1 up: reaches 0 after 26 frames and stays there
        keypressed_1 = 1'b1; keys_1 = 4'h1;
        repeat (25) frame();
        chk("up_25", paddle1_y, 8);
        frame();
        chk("up_sat_26", paddle1_y, 0);
        repeat (4) frame();
        chk("up_sat_30", paddle1_y, 0);

        // Paddle 1 down for 60 frames: saturates at 416; meanwhile ball passes parked paddle 2
        keys_1 = 4'h4;
        repeat (60) frame();
        chk("down_sat", paddle1_y, 416);
        chk("p1_point_state", game_state, 3);
        chk("p1_point_score", score1, 1);
        keypressed_1 = 1'b0; keys_1 = 4'h0;

        // 12 POINT frames already elapsed; 48 more return to SERVE
        repeat (47) frame();
        chk("point_hold", game_state, 3);
        frame();
        chk("point_done", game_state, 1);
        chk("recentre_x", ball_x, 316);
        chk("recentre_y", ball_y, 236);

        // Player 2 serves; ball heads toward the scorer (left) and up
        keypressed_2 = 1'b1; keys_2 = 4'h5; cyc();
        chk("p2_serve", game_state, 2);
        keypressed_2 = 1'b0; keys_2 = 4'h0; cyc();
        frame();
        chk("serve_left_x", ball_x, 312);
        chk("serve_left_y", ball_y, 232);

        // Park paddle 1 at the top, ball climbs to the top wall
        keypressed_1 = 1'b1; keys_1 = 4'h1;
        repeat (52) frame();
        chk("p1_top", paddle1_y, 0);
        keypressed_1 = 1'b0; keys_1 = 4'h0;
        repeat (6) frame();
        chk("wall_touch", ball_y, 0);
        frame();
        chk("wall_clamp", ball_y, 0);
        frame();
        chk("wall_bounce", ball_y, 4);
        repeat (12) frame();
        chk("p1_hit_x", ball_x, 24);
        frame();
        chk("p1_return_x", ball_x, 28);

        // Play out the match: player 1 tracks the ball, player 2 dodges it
        for (int f = 0; f < 4000 && m_st != 4; f++) begin
            if (m_st == 1) begin
                keypressed_1 = 1'b1; keys_1 = 4'h5;
            end else begin
                t1 = m_by - 28;
                if (t1 < 0) t1 = 0;
                if (t1 > 416) t1 = 416;
                if (m_p1 > t1 + 4) begin keypressed_1 = 1'b1; keys_1 = 4'h1; end
                else if (m_p1 < t1 - 4) begin keypressed_1 = 1'b1; keys_1 = 4'h4; end
                else begin keypressed_1 = 1'b0; keys_1 = 4'h0; end
            end
            if (m_st == 2 && m_dx > 0) begin
                t2 = (pred_y() < 240) ? 416 : 0;
                if (m_p2 > t2) begin keypressed_2 = 1'b1; keys_2 = 4'h1; end
                else if (m_p2 < t2) begin keypressed_2 = 1'b1; keys_2 = 4'h4; end
                else begin keypressed_2 = 1'b0; keys_2 = 4'h0; end
            end else begin
                keypressed_2 = 1'b0; keys_2 = 4'h0;
            end
            frame();
        end
        chk("over_state", game_state, 4);
        chk("over_winner", winner, 1);
        chk("over_score1", score1, 9);

        // Keys do nothing in OVER
        keypressed_1 = 1'b1; keys_1 = 4'h4;
        keypressed_2 = 1'b1; keys_2 = 4'h5;
        repeat (5) frame();
        chk("over_frozen", game_state, 4);
        keypressed_1 = 1'b0; keys_1 = 4'h0;
        keypressed_2 = 1'b0; keys_2 = 4'h0;

        // Restart
        start = 1'b1; cyc(); start = 1'b0;
        chk("restart_state", game_state, 1);
        chk("restart_s1", score1, 0);
        chk("restart_win", winner, 0);
        chk("restart_bx", ball_x, 316);
        cyc();

        // Serve, play a little, start edge ignored in PLAY
        keypressed_1 = 1'b1; keys_1 = 4'h5; cyc();
        keypressed_1 = 1'b0; keys_1 = 4'h0; cyc();
        repeat (3) frame();
        start = 1'b1; cyc(); start = 1'b0; cyc();
        chk("start_ignored", game_state, 2);
        frame();

        // Mid-play reset for one cycle, with a frame tick present
        rst_n = 1'b0; frame_tick = 1'b1; cyc();
        rst_n = 1'b1; frame_tick = 1'b0;
        chk_reset_vals("midreset");
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Game-state sequencer for two-player Pong.
- Consumes the debounced key events from both keypad scanners and a per-frame tick derived from VGA vsync.
- Updates paddle positions, ball position/velocity, collisions and scores once per frame.
- Presents object coordinates and score/state to the VGA renderer.

Parameters:
H_RES, 640, visible width in pixels
V_RES, 480, visible height in pixels
PADDLE_H, 64, paddle height
PADDLE_W, 8, paddle width
PADDLE1_X, 16, left edge of player-1 paddle
PADDLE2_X, 616, left edge of player-2 paddle
PADDLE_STEP, 8, paddle pixels per frame while key held
BALL_SIZE, 8, ball square side
BALL_SPEED, 4, ball pixels per frame on each axis
WIN_SCORE, 9, score that ends the game
POINT_FRAMES, 60, frames spent in POINT before next serve
KEY_UP, 4'h1, keypad code for "up"
KEY_DOWN, 4'h4, keypad code for "down"
KEY_SERVE, 4'h5, keypad code for "serve"

Ports:
clk  in  1  system clock (CLOCK_50 domain)
rst_n  in  1  synchronous active-low reset
frame_tick  in  1  one-cycle pulse per frame; all game updates occur only on this cycle
start  in  1  level, active-high start/restart button; rising edge detected internally
keys_1  in  4  player-1 key code
keypressed_1  in  1  player-1 key held (level)
keys_2  in  4  player-2 key code
keypressed_2  in  1  player-2 key held (level)
paddle1_y  out  10  top row of paddle 1
paddle2_y  out  10  top row of paddle 2
ball_x  out  10  left column of ball
ball_y  out  10  top row of ball
score1  out  4  player-1 score
score2  out  4  player-2 score
game_state  out  3  0=IDLE, 1=SERVE, 2=PLAY, 3=POINT, 4=OVER
winner  out  2  0=none, 1=player1, 2=player2

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE.
  - paddle1_y=paddle2_y=(V_RES-PADDLE_H)/2=208.
  - ball=((H_RES-BALL_SIZE)/2, (V_RES-BALL_SIZE)/2)=(316,236).
  - dx=+ (right), dy=+ (down); scores=0; winner=0; point counter=0; start edge-detect register=0.
  - Reset mid-game aborts immediately to these values.
- start_rise = start & ~start_q, evaluated every clk cycle. IDLE or OVER + start_rise -> SERVE; scores, winner and ball reset to initial values. start_rise is ignored in other states.
- Paddles update on frame_tick in SERVE, PLAY and POINT; they are frozen in IDLE and OVER.
  - keypressed_n & keys_n==KEY_UP: y -= PADDLE_STEP, clamped at 0.
  - keypressed_n & keys_n==KEY_DOWN: y += PADDLE_STEP, clamped at V_RES-PADDLE_H=416.
  - Other codes: no move. Clamping is computed in 11 bits; outputs never leave range.
- SERVE: ball held at centre.
  - On the first clk with either keypressed_n & keys_n==KEY_SERVE, go to PLAY. Direction dx is kept from the previous point.
  - Both players serving in the same cycle -> PLAY (no priority needed).
- PLAY, on each frame_tick, in this order:
  - (1) Next position nx=ball_x±BALL_SPEED, ny=ball_y±BALL_SPEED.
  - (2) Wall: ny<0 -> ny=0, dy=+. ny>V_RES-BALL_SIZE -> ny=V_RES-BALL_SIZE, dy=−.
  - (3) Paddle 1, when dx=−: nx<=PADDLE1_X+PADDLE_W and nx+BALL_SIZE>PADDLE1_X and ny+BALL_SIZE>paddle1_y and ny<paddle1_y+PADDLE_H -> nx=PADDLE1_X+PADDLE_W, dx=+.
    - Paddle 2 mirrors this when dx=+: nx=PADDLE2_X-BALL_SIZE, dx=−.
  - (4) Miss: dx=− and nx<=0 -> score2++, dx=+ (next serve toward scorer), state=POINT.
    - dx=+ and nx>=H_RES-BALL_SIZE -> score1++, dx=−, POINT.
    - Paddle hit takes precedence over miss in the same frame. Wall and paddle corner hit in the same frame apply both.
  - (5) Commit ball_x=nx, ball_y=ny. Signed arithmetic uses 11 bits.
- POINT: the ball stays at the exit position.
  - The counter increments per frame_tick; at POINT_FRAMES, the counter clears and the ball recentres.
  - If the score that just changed equals WIN_SCORE: state=OVER, winner=1 or 2. Otherwise state=SERVE.
- OVER: all positions frozen; scores and winner held until start_rise.
- frame_tick asserted during reset is ignored. Outputs are registered; an update becomes visible the cycle after the frame_tick.

Test Plan:
- Reset, then 2 frame_ticks with no keys -> state=0, paddles=208, ball=(316,236), scores 0.
- start pulse, then P1 holds KEY_SERVE -> state 1 then 2. After 1 frame_tick, ball=(320,240).
- P1 holds KEY_UP for 30 frames -> paddle1_y decreases 208,200,… and saturates at 0 after frame 26. KEY_DOWN for 60 frames -> saturates at 416.
- Ball driven by play to y=0 with dy=− -> ball_y=0, dy flips, next frame ball_y=4.
- Paddle 2 parked away; ball travels right -> score1=1, state=3. After 60 frame_ticks -> state=1, ball centred, next serve moves left.
- Score1 at 8, P1 scores -> after POINT_FRAMES, state=4 and winner=1. Keys have no effect; start_rise -> state=1, scores 0.
- Mid-PLAY rst_n=0 for 1 cycle -> all reset values on the following cycle.
